// File: rtl/tag_rx_pkg.sv
// Shared definitions for the tag receive path: FSM encoding, CRC-16 constants
// and the single-bit CRC update used by both the RX check and the TX CRC path.
package tag_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } crc_state_e;

  localparam logic [15:0] CRC16_POLY      = 16'h1021;
  localparam logic [15:0] CRC_PRESET_DEF  = 16'hFFFF;
  localparam logic [15:0] CRC_RESIDUE_DEF = 16'h1D0F;
  localparam logic [15:0] RN16_LEN        = 16'd16;

  // MSB-first CRC-16 step: feedback is the outgoing MSB xor the incoming bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16 register. init presets the register; when init and en are
// both high the incoming bit is folded into the fresh preset in the same cycle.
module crc16_serial
  import tag_rx_pkg::*;
#(
  parameter logic [15:0] PRESET = CRC_PRESET_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        init,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_d, crc_q;

  always_comb begin
    crc_d = crc_q;
    if (init) crc_d = PRESET;
    if (en)   crc_d = crc16_step(crc_d, bit_in);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= PRESET;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/tag_crc_check.sv
// Checks the CRC-16 of a decoded tag reply, classifies RN16 / illegal lengths
// and captures the first 16 reply bits.
module tag_crc_check
  import tag_rx_pkg::*;
#(
  parameter int          DATA_W      = 256,
  parameter logic [15:0] CRC_PRESET  = CRC_PRESET_DEF,
  parameter logic [15:0] CRC_RESIDUE = CRC_RESIDUE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tag_data,
  input  logic              tag_finish,
  input  logic [15:0]       tag_data_number,
  output logic              busy,
  output logic              done,
  output logic              crc_ok,
  output logic              no_crc,
  output logic              len_err,
  output logic [15:0]       rn16
);

  localparam logic [15:0] DATA_W16 = 16'(DATA_W);

  crc_state_e        state_d, state_q;
  logic              fin_d, fin_q;
  logic              armed_d, armed_q;
  logic              start_d, start_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [15:0]       num_d, num_q;
  logic [8:0]        cnt_d, cnt_q;
  logic              crc_ok_d, crc_ok_q;
  logic              no_crc_d, no_crc_q;
  logic              len_err_d, len_err_q;
  logic [15:0]       rn16_d, rn16_q;

  logic              crc_en, crc_init;
  logic [15:0]       crc;
  logic [DATA_W-1:0] aligned;
  logic              start;

  // Left-justify the reply so the first received bit sits at the MSB.
  assign aligned = tag_data << (DATA_W16 - tag_data_number);

  // armed_q blocks a tag_finish level that was already high out of reset.
  assign start = tag_finish & ~fin_q & armed_q & ~start_q & (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    fin_d     = tag_finish;
    armed_d   = armed_q | ~tag_finish;
    start_d   = start;
    data_d    = data_q;
    num_d     = num_q;
    cnt_d     = cnt_q;
    crc_ok_d  = crc_ok_q;
    no_crc_d  = no_crc_q;
    len_err_d = len_err_q;
    rn16_d    = rn16_q;
    crc_en    = 1'b0;
    crc_init  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_q) begin
          if (num_q < RN16_LEN || num_q > DATA_W16) begin
            len_err_d = 1'b1;
            crc_ok_d  = 1'b0;
            no_crc_d  = 1'b0;
            state_d   = ST_DONE;
          end else if (num_q == RN16_LEN) begin
            no_crc_d  = 1'b1;
            crc_ok_d  = 1'b0;
            len_err_d = 1'b0;
            state_d   = ST_DONE;
          end else begin
            // Preset and consume the first bit together; cnt holds bits still to go.
            crc_init = 1'b1;
            crc_en   = 1'b1;
            data_d   = data_q << 1;
            cnt_d    = 9'(num_q - 16'd1);
            state_d  = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (cnt_q == 9'd0) begin
          crc_ok_d  = (crc == CRC_RESIDUE);
          no_crc_d  = 1'b0;
          len_err_d = 1'b0;
          state_d   = ST_DONE;
        end else begin
          crc_en = 1'b1;
          data_d = data_q << 1;
          cnt_d  = cnt_q - 9'd1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (start) begin
      data_d = aligned;
      num_d  = tag_data_number;
      if (tag_data_number >= RN16_LEN && tag_data_number <= DATA_W16)
        rn16_d = aligned[DATA_W-1 -: 16];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      fin_q     <= 1'b0;
      armed_q   <= 1'b0;
      start_q   <= 1'b0;
      data_q    <= '0;
      num_q     <= 16'd0;
      cnt_q     <= 9'd0;
      crc_ok_q  <= 1'b0;
      no_crc_q  <= 1'b0;
      len_err_q <= 1'b0;
      rn16_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      fin_q     <= fin_d;
      armed_q   <= armed_d;
      start_q   <= start_d;
      data_q    <= data_d;
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      crc_ok_q  <= crc_ok_d;
      no_crc_q  <= no_crc_d;
      len_err_q <= len_err_d;
      rn16_q    <= rn16_d;
    end
  end

  crc16_serial #(.PRESET(CRC_PRESET)) u_crc (
    .clk    (clk),
    .rst    (reset),
    .en     (crc_en),
    .init   (crc_init),
    .bit_in (data_q[DATA_W-1]),
    .crc    (crc)
  );

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign crc_ok  = crc_ok_q;
  assign no_crc  = no_crc_q;
  assign len_err = len_err_q;
  assign rn16    = rn16_q;

endmodule

// File: tb/tb_tag_crc_check.sv
// Bench for tag_crc_check: directed frames plus random frames, all outputs
// compared every cycle against a frame-level model using polynomial division.
module tb_tag_crc_check;

  localparam int          DW      = 256;
  localparam logic [15:0] PRESET  = 16'hFFFF;
  localparam logic [15:0] RESIDUE = 16'h1D0F;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tag_finish = 1'b0;
  logic [DW-1:0] tag_data = '0;
  logic [15:0]   tag_data_number = 16'd0;
  logic          busy, done, crc_ok, no_crc, len_err;
  logic [15:0]   rn16;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  tag_crc_check #(.DATA_W(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .tag_data        (tag_data),
    .tag_finish      (tag_finish),
    .tag_data_number (tag_data_number),
    .busy            (busy),
    .done            (done),
    .crc_ok          (crc_ok),
    .no_crc          (no_crc),
    .len_err         (len_err),
    .rn16            (rn16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Register contents after n bits = (init*x^n + M*x^16) mod G.
  function automatic logic [15:0] ref_crc(input logic [DW-1:0] d, input int n,
                                          input logic [15:0] init);
    logic [DW+15:0] v;
    v = '0;
    for (int i = 0; i < n; i++)  v[i+16] = d[i];
    for (int i = 0; i < 16; i++) v[n+i] = v[n+i] ^ init[i];
    for (int i = n + 15; i >= 16; i--)
      if (v[i]) v[i -: 17] = v[i -: 17] ^ 17'h11021;
    return v[15:0];
  endfunction

  // Frame-level model state.
  bit          m_prev = 0, m_armed = 0, m_active = 0;
  int          m_k = 0, m_done = 0;
  logic [15:0] m_rn16 = 16'h0;
  bit          m_ok = 0, m_noc = 0, m_len = 0;
  bit          p_ok = 0, p_noc = 0, p_len = 0;

  always @(negedge clk) begin
    bit acc;
    int n;
    if (reset) begin
      m_prev = 0; m_armed = 0; m_active = 0;
      m_rn16 = 16'h0; m_ok = 0; m_noc = 0; m_len = 0;
    end else begin
      if (m_active && cyc > m_done + 1) m_active = 0;
      acc = tag_finish && !m_prev && m_armed && !m_active;
      if (!tag_finish) m_armed = 1;
      m_prev = tag_finish;
      if (acc) begin
        n = int'(tag_data_number);
        m_active = 1;
        m_k = cyc;
        p_len = (n < 16) || (n > DW);
        p_noc = (n == 16);
        p_ok = !p_len && !p_noc && (ref_crc(tag_data, n, PRESET) == RESIDUE);
        m_done = cyc + ((p_len || p_noc) ? 1 : n + 1);
        if (!p_len)
          for (int i = 0; i < 16; i++) m_rn16[15-i] = tag_data[n-1-i];
      end
      if (m_active && cyc == m_done) begin
        m_ok = p_ok; m_noc = p_noc; m_len = p_len;
      end
    end
    chk("busy",    busy,    m_active && cyc >= m_k + 1 && cyc <= m_done);
    chk("done",    done,    m_active && cyc == m_done);
    chk("crc_ok",  crc_ok,  m_ok);
    chk("no_crc",  no_crc,  m_noc);
    chk("len_err", len_err, m_len);
    chk("rn16",    rn16,    m_rn16);
  end

  // mode 0: plain frame; 1: re-pulse tag_finish and change inputs mid-frame;
  // 2: assert reset at edge k+40. lat = done latency from edge k (-1 timeout, -2 reset).
  task automatic run_frame(input int n, input logic [DW-1:0] d, input int mode, output int lat);
    int k;
    lat = -1;
    @(negedge clk); #1 tag_finish = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tag_data = d;
    tag_data_number = 16'(n);
    tag_finish = 1'b1;
    k = cyc + 1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - k;
        break;
      end
      if (mode == 1 && cyc - k == 20) begin #1 tag_finish = 1'b0; end
      if (mode == 1 && cyc - k == 29) begin #1 tag_finish = 1'b1; end
      if (mode == 1 && cyc - k == 31) begin
        #1 tag_data = ~d;
        tag_data_number = 16'd40;
      end
      if (mode == 2 && cyc - k == 39) begin
        #1 reset = 1'b1;
        #1;
        chk("rst_busy",    busy,    0);
        chk("rst_done",    done,    0);
        chk("rst_crc_ok",  crc_ok,  0);
        chk("rst_no_crc",  no_crc,  0);
        chk("rst_len_err", len_err, 0);
        chk("rst_rn16",    rn16,    0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        lat = -2;
        break;
      end
    end
  endtask

  initial begin
    int lat, n, sel, seen;
    logic [DW-1:0] good, d, r;
    tag_finish = 1'b1;
    repeat (3) @(negedge clk);
    chk("init_busy",    busy,    0);
    chk("init_done",    done,    0);
    chk("init_crc_ok",  crc_ok,  0);
    chk("init_no_crc",  no_crc,  0);
    chk("init_len_err", len_err, 0);
    chk("init_rn16",    rn16,    0);

    good = '0;
    good[87:0] = {72'h313233343536373839, 16'hD64E};
    d = good >> 16;
    chk("pin_crc_123456789", ref_crc(d, 72, PRESET), 16'h29B1);
    chk("pin_residue",       ref_crc(good, 88, PRESET), RESIDUE);

    // tag_finish already high at reset release must not start a frame.
    #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_high_busy", busy, 0);

    run_frame(88, good, 0, lat);
    chk("good_lat",  lat, 89);
    chk("good_ok",   crc_ok, 1);
    chk("good_len",  len_err, 0);
    chk("good_rn16", rn16, 16'h3132);

    d = good;
    d[40] = ~d[40];
    run_frame(88, d, 0, lat);
    chk("bad_lat", lat, 89);
    chk("bad_ok",  crc_ok, 0);
    chk("bad_len", len_err, 0);

    d = '0;
    d[15:0] = 16'hA5C3;
    run_frame(16, d, 0, lat);
    chk("rn_lat",  lat, 1);
    chk("rn_noc",  no_crc, 1);
    chk("rn_ok",   crc_ok, 0);
    chk("rn_rn16", rn16, 16'hA5C3);

    d = ~good;
    run_frame(12, d, 0, lat);
    chk("short_lat",  lat, 1);
    chk("short_len",  len_err, 1);
    chk("short_ok",   crc_ok, 0);
    chk("short_rn16", rn16, 16'hA5C3);
    run_frame(300, d, 0, lat);
    chk("long_lat",  lat, 1);
    chk("long_len",  len_err, 1);
    chk("long_ok",   crc_ok, 0);
    chk("long_rn16", rn16, 16'hA5C3);

    run_frame(88, good, 1, lat);
    chk("retrig_lat", lat, 89);
    chk("retrig_ok",  crc_ok, 1);

    run_frame(88, good, 2, lat);
    chk("abort_lat", lat, -2);
    seen = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("abort_no_done", seen, 0);

    run_frame(88, good, 0, lat);
    chk("after_rst_lat",  lat, 89);
    chk("after_rst_ok",   crc_ok, 1);
    chk("after_rst_rn16", rn16, 16'h3132);

    for (int f = 0; f < 40; f++) begin
      for (int w = 0; w < DW / 32; w++) r[w*32 +: 32] = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       n = $urandom_range(0, 15);
        1:       n = 16;
        2:       n = $urandom_range(DW + 1, 65535);
        3:       n = DW;
        4:       n = 17;
        default: n = $urandom_range(17, DW);
      endcase
      if (n > 16 && n <= DW && $urandom_range(0, 1) == 1)
        r[15:0] = ~ref_crc(r >> 16, n - 16, PRESET);
      run_frame(n, r, ($urandom_range(0, 3) == 0) ? 1 : 0, lat);
      chk("rand_lat", lat, (n > 16 && n <= DW) ? n + 1 : 1);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
